fpcsr_unit: RTL and testbench
=============================

Name: fpcsr_unit

Overview:
User-mode floating-point CSR unit holding frm and fflags (fflags/frm/fcsr at 0x001/0x002/0x003). It accumulates exception flags from NSRC pipelined FPU lanes and from a long-latency divide/sqrt unit. It tracks outstanding long-latency ops in a bounded scoreboard counter, stalls fflags/fcsr accesses until flags are final, and flags reserved dynamic rounding modes. It sits in the privileged CSR block beside the machine/supervisor CSR units and feeds the FPU rounding mode.

Parameters:
XLEN, 64, CSR data width (32 or 64)
NSRC, 2, number of M-stage flag-setting FPU lanes (1..4)
PENDDEPTH, 4, max outstanding long-latency FP ops (1..15)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
InstrValidNotFlushedM  in  1  M-stage instruction commits this cycle
CSRUReadM  in  1  CSR read of user FP CSR in M
CSRUWriteM  in  1  CSR write of user FP CSR in M
CSRAdrM  in  12  CSR address
CSRWriteValM  in  XLEN  CSR write data
STATUS_FS  in  2  mstatus.FS
SetFflagsM  in  5*NSRC  per-lane flags, lane i at [5i+4:5i]
SetFflagsValidM  in  NSRC  per-lane flag valid
LongOpIssueM  in  1  long-latency FP op issues in M
LongOpDoneW  in  1  long-latency op completes
LongOpFlagsW  in  5  flags of completing long op
InstrDynRMM  in  1  M-stage FP instr uses rm=DYN
LongOpReadyM  out  1  scoreboard can accept an issue
CSRUStallM  out  1  stall M: FP CSR access waiting on pending ops
CSRUReadValM  out  XLEN  read data
FRM_REGW  out  3  current frm
IllegalRMM  out  1  DYN with reserved frm
IllegalCSRUAccessM  out  1  illegal access
SetFSDirtyM  out  1  request mstatus.FS := Dirty
WriteFRMM  out  1  frm committed this cycle

Behaviour:
- Reset is synchronous on the clk edge with reset_n=0. Registers clear: FRM=0, FFLAGS=0, pending count=0. Consequently LongOpReadyM=1, CSRUStallM=0 and IllegalRMM=0 after reset.
- Reset asserted mid-operation discards the pending count. A LongOpDoneW arriving while count==0 is ignored and the count does not underflow.
- FPU enable: FPEn = (STATUS_FS != 0).
- Scoreboard count, width clog2(PENDDEPTH+1):
  - Issue = LongOpIssueM & InstrValidNotFlushedM & LongOpReadyM.
  - Issue only: count+1. Done only (count>0): count-1. Issue and done together: count unchanged.
  - LongOpReadyM = (count != PENDDEPTH). There is no same-cycle bypass from done, so a full counter blocks issue even if a done arrives that cycle.
- Stall: CSRUStallM = (CSRUReadM|CSRUWriteM) & FPEn & (CSRAdrM==FFLAGS|CSRAdrM==FCSR) & (count!=0). frm-only accesses never stall.
- Commit qualifier: Acc = InstrValidNotFlushedM & ~CSRUStallM.
- Write enables:
  - WriteFRMM = CSRUWriteM & Acc & FPEn & (adr==FRM|adr==FCSR).
  - WriteFF = CSRUWriteM & Acc & FPEn & (adr==FFLAGS|adr==FCSR).
- Write values:
  - frm takes CSRWriteValM[7:5] for FCSR, else CSRWriteValM[2:0].
  - fflags takes CSRWriteValM[4:0].
  - Upper bits are ignored.
- Flag accumulation:
  - SetM = OR over lanes i of (SetFflagsM lane i & {5{SetFflagsValidM[i]}}), gated by InstrValidNotFlushedM & FPEn.
  - SetW = LongOpFlagsW gated by LongOpDoneW & (count!=0).
  - Next FFLAGS = WriteFF ? write value : FFLAGS | SetM | SetW.
  - CSR write wins over same-cycle M-stage sets. A write cannot coincide with SetW because count!=0 stalls the write.
- SetFSDirtyM = FPEn & (WriteFRMM | WriteFF | |SetM | |SetW). It is combinational and asserts even if the flag bits are already set.
- Reads are combinational:
  - FFLAGS: zero-extended {FFLAGS}.
  - FRM: zero-extended {FRM}.
  - FCSR: zero-extended {FRM, FFLAGS}.
  - Read data is only meaningful when CSRUStallM=0.
- IllegalCSRUAccessM = (CSRUReadM|CSRUWriteM) & (~FPEn | address not in {0x001, 0x002, 0x003}). CSRUReadValM=0 whenever illegal.
- IllegalRMM = InstrDynRMM & (FRM_REGW >= 5). It does not block any state update in this block.
- All register updates take effect on the next clk edge, i.e. one-cycle write latency. A read in the following cycle returns the new value.

Test Plan:
- Reset then write fcsr=0xE5 with FS=1 -> next cycle FRM_REGW=7, fflags read=0x05, SetFSDirtyM=1 during write; then InstrDynRMM=1 -> IllegalRMM=1.
- NSRC=2: lane0 flags 0x01 valid, lane1 flags 0x10 valid, same cycle as fflags write of 0x04 -> fflags=0x04; next cycle lane sets only -> fflags=0x15.
- Issue PENDDEPTH=4 long ops -> LongOpReadyM=0; further issue ignored (count stays 4); one LongOpDoneW -> LongOpReadyM=1 next cycle.
- One long op pending, read fflags -> CSRUStallM=1; LongOpDoneW with flags 0x08 -> stall drops next cycle, read returns 0x08; read of frm during pending -> no stall.
- FS=0: write fcsr and lane sets -> IllegalCSRUAccessM=1, read=0, FRM/FFLAGS unchanged, SetFSDirtyM=0; address 0x004 with FS=1 -> illegal.
- Two ops pending, reset_n=0 one cycle -> count=0, FRM=0, FFLAGS=0; subsequent LongOpDoneW -> ignored, fflags stays 0.

Source files
------------

// File: rtl/fpcsr_unit.sv
// fpcsr_unit: user floating-point CSRs (fflags/frm/fcsr) with long-op flag scoreboard
// Ports: clk/reset_n (sync, active-low); CSRU* M-stage CSR access, read data, stall, illegal;
// SetFflags* per-lane M-stage flags; LongOp* long-latency issue/complete/flags and ready;
// FRM_REGW/IllegalRMM rounding mode out and reserved-DYN check; SetFSDirtyM/WriteFRMM status hooks.
module fpcsr_unit #(
  parameter int XLEN = 64,
  parameter int NSRC = 2,
  parameter int PENDDEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              InstrValidNotFlushedM,
  input  logic              CSRUReadM,
  input  logic              CSRUWriteM,
  input  logic [11:0]       CSRAdrM,
  input  logic [XLEN-1:0]   CSRWriteValM,
  input  logic [1:0]        STATUS_FS,
  input  logic [5*NSRC-1:0] SetFflagsM,
  input  logic [NSRC-1:0]   SetFflagsValidM,
  input  logic              LongOpIssueM,
  input  logic              LongOpDoneW,
  input  logic [4:0]        LongOpFlagsW,
  input  logic              InstrDynRMM,
  output logic              LongOpReadyM,
  output logic              CSRUStallM,
  output logic [XLEN-1:0]   CSRUReadValM,
  output logic [2:0]        FRM_REGW,
  output logic              IllegalRMM,
  output logic              IllegalCSRUAccessM,
  output logic              SetFSDirtyM,
  output logic              WriteFRMM
);
  localparam int CW = $clog2(PENDDEPTH + 1);
  logic [CW-1:0] count;
  logic [2:0] frm;
  logic [4:0] fflags, set_lanes, set_m, set_w;
  logic fp_en, adr_ff, adr_frm, adr_fcsr, access, pending, issue, done, acc, write_ff;
  logic unused;
  assign unused = ^CSRWriteValM[XLEN-1:8];
  assign fp_en = |STATUS_FS;
  assign adr_ff = CSRAdrM == 12'h001;
  assign adr_frm = CSRAdrM == 12'h002;
  assign adr_fcsr = CSRAdrM == 12'h003;
  assign access = CSRUReadM | CSRUWriteM;
  assign pending = count != '0;
  assign LongOpReadyM = count != CW'(PENDDEPTH);
  assign issue = LongOpIssueM & InstrValidNotFlushedM & LongOpReadyM;
  // a completion with nothing outstanding is spurious and must not underflow or set flags
  assign done = LongOpDoneW & pending;
  // fflags are not final until every long op has reported its flags
  assign CSRUStallM = access & fp_en & (adr_ff | adr_fcsr) & pending;
  assign acc = InstrValidNotFlushedM & ~CSRUStallM;
  assign WriteFRMM = CSRUWriteM & acc & fp_en & (adr_frm | adr_fcsr);
  assign write_ff = CSRUWriteM & acc & fp_en & (adr_ff | adr_fcsr);
  always_comb begin
    set_lanes = '0;
    for (int i = 0; i < NSRC; i++)
      set_lanes = set_lanes | (SetFflagsM[5*i +: 5] & {5{SetFflagsValidM[i]}});
  end
  assign set_m = (InstrValidNotFlushedM & fp_en) ? set_lanes : '0;
  assign set_w = done ? LongOpFlagsW : '0;
  assign SetFSDirtyM = fp_en & (WriteFRMM | write_ff | |set_m | |set_w);
  assign IllegalCSRUAccessM = access & (~fp_en | ~(adr_ff | adr_frm | adr_fcsr));
  assign CSRUReadValM = IllegalCSRUAccessM ? '0 :
                        adr_ff   ? XLEN'(fflags) :
                        adr_frm  ? XLEN'(frm) :
                        adr_fcsr ? XLEN'({frm, fflags}) : '0;
  assign FRM_REGW = frm;
  assign IllegalRMM = InstrDynRMM & (frm >= 3'd5);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
      frm <= '0;
      fflags <= '0;
    end else begin
      count <= (issue & ~done) ? count + CW'(1) : (done & ~issue) ? count - CW'(1) : count;
      if (WriteFRMM) frm <= adr_fcsr ? CSRWriteValM[7:5] : CSRWriteValM[2:0];
      fflags <= write_ff ? CSRWriteValM[4:0] : (fflags | set_m | set_w);
    end
  end
endmodule

// File: tb/tb_fpcsr_unit.sv
// tb_fpcsr_unit: scoreboard bench for fpcsr_unit against a queue-based reference model
module tb_fpcsr_unit;
  localparam int XLEN = 64;
  localparam int NSRC = 2;
  localparam int PENDDEPTH = 4;
  logic clk = 0;
  logic reset_n, InstrValidNotFlushedM, CSRUReadM, CSRUWriteM, LongOpIssueM, LongOpDoneW, InstrDynRMM;
  logic [11:0] CSRAdrM;
  logic [XLEN-1:0] CSRWriteValM, CSRUReadValM;
  logic [1:0] STATUS_FS;
  logic [5*NSRC-1:0] SetFflagsM;
  logic [NSRC-1:0] SetFflagsValidM;
  logic [4:0] LongOpFlagsW;
  logic LongOpReadyM, CSRUStallM, IllegalRMM, IllegalCSRUAccessM, SetFSDirtyM, WriteFRMM;
  logic [2:0] FRM_REGW;

  fpcsr_unit #(.XLEN(XLEN), .NSRC(NSRC), .PENDDEPTH(PENDDEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .InstrValidNotFlushedM(InstrValidNotFlushedM),
    .CSRUReadM(CSRUReadM), .CSRUWriteM(CSRUWriteM), .CSRAdrM(CSRAdrM), .CSRWriteValM(CSRWriteValM),
    .STATUS_FS(STATUS_FS), .SetFflagsM(SetFflagsM), .SetFflagsValidM(SetFflagsValidM),
    .LongOpIssueM(LongOpIssueM), .LongOpDoneW(LongOpDoneW), .LongOpFlagsW(LongOpFlagsW),
    .InstrDynRMM(InstrDynRMM), .LongOpReadyM(LongOpReadyM), .CSRUStallM(CSRUStallM),
    .CSRUReadValM(CSRUReadValM), .FRM_REGW(FRM_REGW), .IllegalRMM(IllegalRMM),
    .IllegalCSRUAccessM(IllegalCSRUAccessM), .SetFSDirtyM(SetFSDirtyM), .WriteFRMM(WriteFRMM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, ivalid, rd, wr, iss, done, dyn;
    logic [11:0] adr;
    logic [63:0] wval;
    logic [1:0] fs;
    logic [5*NSRC-1:0] sf;
    logic [NSRC-1:0] sfv;
    logic [4:0] lflags;
  } stim_t;

  typedef struct {
    logic ready, stall, illrm, illacc, dirty, wfrm;
    logic [63:0] rdval;
    logic [2:0] frm;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // reference state: outstanding long ops as a queue, CSR fields as plain values
  bit pend[$];
  logic [2:0] m_frm = 0;
  logic [4:0] m_ff = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.fs = 2'd1;
    return s;
  endfunction

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, got, want, $time);
    end
  endtask

  task automatic apply(input stim_t s);
    reset_n = ~s.rst;
    InstrValidNotFlushedM = s.ivalid;
    CSRUReadM = s.rd;
    CSRUWriteM = s.wr;
    CSRAdrM = s.adr;
    CSRWriteValM = s.wval;
    STATUS_FS = s.fs;
    SetFflagsM = s.sf;
    SetFflagsValidM = s.sfv;
    LongOpIssueM = s.iss;
    LongOpDoneW = s.done;
    LongOpFlagsW = s.lflags;
    InstrDynRMM = s.dyn;
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    bit fpen, access, is_ff, is_frm, acc, wff, issue, dn;
    logic [4:0] sm, sw;
    apply(s);
    fpen = s.fs != 2'd0;
    access = s.rd || s.wr;
    is_ff = s.adr == 12'h001 || s.adr == 12'h003;
    is_frm = s.adr == 12'h002 || s.adr == 12'h003;
    e.ready = pend.size() < PENDDEPTH;
    e.stall = access && fpen && is_ff && pend.size() > 0;
    acc = s.ivalid && !e.stall;
    e.wfrm = s.wr && acc && fpen && is_frm;
    wff = s.wr && acc && fpen && is_ff;
    sm = 0;
    for (int i = 0; i < NSRC; i++) if (s.sfv[i]) sm = sm | s.sf[5*i +: 5];
    if (!(s.ivalid && fpen)) sm = 0;
    dn = s.done && pend.size() > 0;
    sw = dn ? s.lflags : 5'd0;
    e.illacc = access && (!fpen || s.adr < 12'h001 || s.adr > 12'h003);
    case (s.adr)
      12'h001: e.rdval = 64'(m_ff);
      12'h002: e.rdval = 64'(m_frm);
      12'h003: e.rdval = 64'({m_frm, m_ff});
      default: e.rdval = 0;
    endcase
    if (e.illacc) e.rdval = 0;
    e.dirty = fpen && (e.wfrm || wff || sm != 0 || sw != 0);
    e.illrm = s.dyn && m_frm >= 3'd5;
    e.frm = m_frm;
    q.push_back(e);
    issue = s.iss && s.ivalid && e.ready;
    if (s.rst) begin
      pend.delete();
      m_frm = 0;
      m_ff = 0;
    end else begin
      if (issue) pend.push_back(1'b1);
      if (dn) void'(pend.pop_front());
      if (e.wfrm) m_frm = (s.adr == 12'h003) ? s.wval[7:5] : s.wval[2:0];
      m_ff = wff ? s.wval[4:0] : (m_ff | sm | sw);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ready", 64'(LongOpReadyM), 64'(e.ready));
        chk("stall", 64'(CSRUStallM), 64'(e.stall));
        chk("rdval", CSRUReadValM, e.rdval);
        chk("frm", 64'(FRM_REGW), 64'(e.frm));
        chk("illrm", 64'(IllegalRMM), 64'(e.illrm));
        chk("illacc", 64'(IllegalCSRUAccessM), 64'(e.illacc));
        chk("dirty", 64'(SetFSDirtyM), 64'(e.dirty));
        chk("wfrm", 64'(WriteFRMM), 64'(e.wfrm));
      end
    end
  end

  initial begin
    stim_t s;
    s = idle();
    s.rst = 1;
    apply(s);
    @(posedge clk);
    #1;
    step(s);
    // fcsr write then readback and reserved-DYN detection
    s = idle(); s.ivalid = 1; s.wr = 1; s.adr = 12'h003; s.wval = 64'hFFFF_FF00_0000_00E5; step(s);
    s = idle(); s.ivalid = 1; s.rd = 1; s.adr = 12'h001; step(s);
    s = idle(); s.dyn = 1; s.rd = 1; s.adr = 12'h003; step(s);
    // write beats same-cycle lane sets, then lanes accumulate
    s = idle(); s.ivalid = 1; s.wr = 1; s.adr = 12'h001; s.wval = 64'h4;
    s.sf = {5'h10, 5'h01}; s.sfv = 2'b11; step(s);
    s = idle(); s.ivalid = 1; s.sf = {5'h10, 5'h01}; s.sfv = 2'b11; step(s);
    s = idle(); s.rd = 1; s.adr = 12'h001; step(s);
    // fill the scoreboard, attempt overflow, and retire one
    for (int i = 0; i < PENDDEPTH + 2; i++) begin
      s = idle(); s.ivalid = 1; s.iss = 1; step(s);
    end
    s = idle(); s.ivalid = 1; s.iss = 1; s.done = 1; s.lflags = 5'h02; step(s);
    s = idle(); s.done = 1; s.lflags = 5'h02; step(s);
    s = idle(); step(s);
    for (int i = 0; i < PENDDEPTH + 1; i++) begin
      s = idle(); s.done = 1; step(s);
    end
    // stall on fflags while one op pending; frm access never stalls
    s = idle(); s.ivalid = 1; s.wr = 1; s.adr = 12'h001; s.wval = 64'h0; step(s);
    s = idle(); s.ivalid = 1; s.iss = 1; step(s);
    s = idle(); s.ivalid = 1; s.rd = 1; s.adr = 12'h001; step(s);
    s = idle(); s.ivalid = 1; s.rd = 1; s.adr = 12'h002; step(s);
    s = idle(); s.ivalid = 1; s.rd = 1; s.adr = 12'h001; s.done = 1; s.lflags = 5'h08; step(s);
    s = idle(); s.ivalid = 1; s.rd = 1; s.adr = 12'h001; step(s);
    // FPU off: everything illegal and nothing changes
    s = idle(); s.fs = 0; s.ivalid = 1; s.wr = 1; s.adr = 12'h003; s.wval = 64'h1F;
    s.sf = {5'h1F, 5'h1F}; s.sfv = 2'b11; step(s);
    s = idle(); s.ivalid = 1; s.rd = 1; s.adr = 12'h003; step(s);
    s = idle(); s.ivalid = 1; s.rd = 1; s.adr = 12'h004; step(s);
    // reset with ops pending, then a spurious completion
    s = idle(); s.ivalid = 1; s.iss = 1; step(s);
    step(s);
    s = idle(); s.rst = 1; step(s);
    s = idle(); s.done = 1; s.lflags = 5'h1F; step(s);
    s = idle(); s.rd = 1; s.adr = 12'h003; step(s);
    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      s.rst = ($urandom % 60) == 0;
      s.ivalid = ($urandom % 4) != 0;
      s.rd = ($urandom % 3) == 0;
      s.wr = ($urandom % 4) == 0;
      s.adr = 12'($urandom % 6);
      s.wval = {$urandom, $urandom};
      s.fs = (($urandom % 6) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      s.sf = (5*NSRC)'($urandom);
      s.sfv = NSRC'($urandom);
      s.iss = ($urandom % 3) == 0;
      s.done = ($urandom % 3) == 0;
      s.lflags = 5'($urandom);
      s.dyn = 1'($urandom);
      step(s);
    end
    apply(idle());
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
